aes_key_expand: RTL and testbench

AES_KEY_EXPAND -- requirements
Module: aes_key_expand

---
 rtl/aes_key_expand.sv | 126 ++++++++++++
 tb/tb_aes_key_expand.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// AES key schedule: expands NK-word cipher key one word per cycle into a round-key store.
// Define AES_KEYEXP_ZEROIZE_EN to add a zeroize input that wipes key material and aborts.
module aes_key_expand #(
  parameter int NK    = 8,
  parameter int NR    = 14,
  parameter int KEY_W = 256
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef AES_KEYEXP_ZEROIZE_EN
  input  logic             zeroize,
`endif
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  output logic             ready,
  output logic             done,
  output logic             valid,
  input  logic [3:0]       rk_idx,
  output logic [127:0]     rk_out
);
  localparam int         NW   = 4 * (NR + 1);
  localparam logic [5:0] LAST = 6'(NW - 1);
  localparam logic [5:0] NK_W = 6'(NK);
  localparam logic [2:0] JMAX = 3'(NK - 1);
  localparam logic [3:0] NR_W = 4'(NR);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;
  state_t state, state_nxt;

  logic [NW-1:0][31:0] w;
  logic [5:0]          i;
  logic [2:0]          j;      // tracks i mod NK without a divider
  logic [7:0]          rcon;
  logic [31:0]         prev, sub_in, sub_out, temp;
  logic [3:0]          rk_sel;

  assign ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = GEN;
      GEN:     if (i == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
`ifdef AES_KEYEXP_ZEROIZE_EN
    if (zeroize) state_nxt = IDLE;
`endif
  end

  assign prev   = w[i - 6'd1];
  assign sub_in = (j == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign sub_out[8*b +: 8] = SBOX[sub_in[8*b +: 8]];
  end

  always_comb begin
    temp = prev;
    if (j == 3'd0)                   temp = sub_out ^ {rcon, 24'h0};
    else if (NK == 8 && j == 3'd4)   temp = sub_out;
  end

  assign rk_sel = (rk_idx > NR_W) ? 4'd0 : rk_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w      <= '0;
      i      <= '0;
      j      <= '0;
      rcon   <= 8'h01;
      done   <= 1'b0;
      valid  <= 1'b0;
      rk_out <= '0;
    end
`ifdef AES_KEYEXP_ZEROIZE_EN
    else if (zeroize) begin
      w      <= '0;
      i      <= '0;
      j      <= '0;
      rcon   <= 8'h01;
      done   <= 1'b0;
      valid  <= 1'b0;
      rk_out <= '0;
    end
`endif
    else begin
      done   <= 1'b0;
      rk_out <= (rk_idx > NR_W) ? '0 :
                {w[{rk_sel, 2'd0}], w[{rk_sel, 2'd1}], w[{rk_sel, 2'd2}], w[{rk_sel, 2'd3}]};
      if (state == IDLE && start) begin
        for (int k = 0; k < NK; k++) w[k] <= key[KEY_W-1-32*k -: 32];
        i     <= NK_W;
        j     <= '0;
        rcon  <= 8'h01;
        valid <= 1'b0;
      end else if (state == GEN) begin
        w[i] <= w[i - NK_W] ^ temp;
        i    <= i + 6'd1;
        j    <= (j == JMAX) ? 3'd0 : j + 3'd1;
        if (j == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        if (i == LAST) begin
          done  <= 1'b1;
          valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboarded bench: NK=4/6/8 instances against an algebraic (GF inverse + affine) AES key schedule model.
module tb_aes_key_expand;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [2:0]       start_v = '0;
  logic [127:0]     key4 = '0;
  logic [191:0]     key6 = '0;
  logic [255:0]     key8 = '0;
  logic [3:0]       rk_idx = '0;
  logic [2:0]       ready_v, done_v, valid_v;
  logic [2:0][127:0] rk_v;
`ifdef AES_KEYEXP_ZEROIZE_EN
  logic             zeroize = 1'b0;
`endif

  always #5 clk = ~clk;

  aes_key_expand #(.NK(4), .NR(10), .KEY_W(128)) u_nk4 (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_KEYEXP_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .start(start_v[0]), .key(key4), .ready(ready_v[0]), .done(done_v[0]),
    .valid(valid_v[0]), .rk_idx(rk_idx), .rk_out(rk_v[0]));

  aes_key_expand #(.NK(6), .NR(12), .KEY_W(192)) u_nk6 (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_KEYEXP_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .start(start_v[1]), .key(key6), .ready(ready_v[1]), .done(done_v[1]),
    .valid(valid_v[1]), .rk_idx(rk_idx), .rk_out(rk_v[1]));

  aes_key_expand #(.NK(8), .NR(14), .KEY_W(256)) u_nk8 (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_KEYEXP_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .start(start_v[2]), .key(key8), .ready(ready_v[2]), .done(done_v[2]),
    .valid(valid_v[2]), .rk_idx(rk_idx), .rk_out(rk_v[2]));

  typedef struct packed { logic [1:0] n; logic [31:0] cyc; } done_t;
  typedef struct packed { logic [3:0] r; logic [2:0] chk; logic [2:0][127:0] e; } rd_t;

  done_t       done_q[$];
  rd_t         rd_q[$];
  done_t       de;
  rd_t         re;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic        rd_req = 1'b0;
  logic        pend;
  logic [7:0]  sbt [256];
  logic [31:0] mw [3][60];
  logic [2:0]  exp_valid = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
      b = inv;
      sbt[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
  endfunction

  task automatic expand(input int n);
    logic [255:0] kk;
    logic [31:0]  t;
    logic [7:0]   rc;
    int nk, nw;
    nk = 4 + 2 * n;
    nw = 4 * (nk + 7);
    kk = (n == 0) ? {key4, 128'h0} : (n == 1) ? {key6, 64'h0} : key8;
    for (int q = 0; q < 60; q++) mw[n][q] = '0;
    for (int q = 0; q < nk; q++) mw[n][q] = kk[255-32*q -: 32];
    rc = 8'h01;
    for (int q = nk; q < nw; q++) begin
      t = mw[n][q-1];
      if (q % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && q % nk == 4) begin
        t = subw(t);
      end
      mw[n][q] = mw[n][q-nk] ^ t;
    end
  endtask

  task automatic clear_model();
    for (int n = 0; n < 3; n++)
      for (int q = 0; q < 60; q++) mw[n][q] = '0;
  endtask

  function automatic logic [127:0] rk_exp(input int n, input int r);
    if (r > 4 + 2 * n + 6) return '0;
    return {mw[n][4*r], mw[n][4*r+1], mw[n][4*r+2], mw[n][4*r+3]};
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    forever begin
      @(posedge clk);
      pend = rd_req;
      #1;
      for (int n = 0; n < 3; n++) begin
        if (done_v[n]) begin
          checks++;
          if (done_q.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected dut=%0d cycle=%0d", n, cyc);
          end else begin
            de = done_q.pop_front();
            if (de.n != 2'(n) || de.cyc != cyc) begin
              errors++;
              $display("FAIL done_timing dut=%0d cycle=%0d exp dut=%0d cycle=%0d", n, cyc, de.n, de.cyc);
            end
          end
          chk($sformatf("valid_at_done dut=%0d", n), 128'(valid_v[n]), 128'(1));
        end
      end
      if (pend) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected cycle=%0d", cyc);
        end else begin
          re = rd_q.pop_front();
          for (int n = 0; n < 3; n++)
            if (re.chk[n]) chk($sformatf("rk nk=%0d idx=%0d", 4 + 2 * n, re.r), rk_v[n], re.e[n]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic rand_keys();
    logic [255:0] t;
    t = rnd256(); key4 = t[255:128];
    t = rnd256(); key6 = t[255:64];
    key8 = rnd256();
  endtask

  task automatic start_run(input logic [2:0] en, input bit completes);
    done_t d;
    for (int n = 0; n < 3; n++) begin
      if (en[n] && completes) begin
        expand(n);
        d.n   = 2'(n);
        d.cyc = 32'(cyc + 1 + (4 * (4 + 2 * n + 7) - (4 + 2 * n)));
        done_q.push_back(d);
      end
    end
    start_v = en;
    @(negedge clk);
    start_v = '0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (ready_v != 3'b111 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("wait_idle", 128'(ready_v), 128'(3'b111));
  endtask

  task automatic rd(input int r, input logic [2:0] m, input logic [127:0] e0, e1, e2);
    rd_t e;
    e.r = 4'(r); e.chk = m; e.e[0] = e0; e.e[1] = e1; e.e[2] = e2;
    rd_q.push_back(e);
    rk_idx = 4'(r);
    rd_req = 1'b1;
    @(negedge clk);
  endtask

  task automatic sweep();
    int off, r;
    chk("valid_level", 128'(valid_v), 128'(exp_valid));
    off = int'($urandom_range(0, 15));
    for (int s = 0; s < 16; s++) begin
      r = (s + off) % 16;
      rd(r, 3'b111, rk_exp(0, r), rk_exp(1, r), rk_exp(2, r));
    end
    rd_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin : stim
    int t;
    build_sbox();
    repeat (3) @(negedge clk);
    chk("reset_ready", 128'(ready_v), 128'(3'b111));
    chk("reset_done", 128'(done_v), 128'(0));
    chk("reset_valid", 128'(valid_v), 128'(0));
    chk("reset_rk", rk_v[0] | rk_v[1] | rk_v[2], 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // published vectors
    key4 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    key6 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    key8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    start_run(3'b111, 1'b1);
    chk("busy_ready", 128'(ready_v), 128'(0));
    wait_idle();
    exp_valid = 3'b111;
    rd(1,  3'b001, 128'ha0fafe1788542cb123a339392a6c7605, '0, '0);
    rd(2,  3'b100, '0, '0, 128'h9ba354118e6925afa51a8b5f2067fcde);
    rd(10, 3'b001, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, '0, '0);
    rd(12, 3'b010, '0, 128'he98ba06f448c773c8ecc720401002202, '0);
    rd(14, 3'b100, '0, '0, 128'hfe4890d1e6188d0b046df344706c631e);
    rd(15, 3'b111, '0, '0, '0);
    rd_req = 1'b0;
    @(negedge clk);
    sweep();

    // random keys
    for (int k = 0; k < 3; k++) begin
      rand_keys();
      start_run(3'b111, 1'b1);
      chk("valid_cleared", 128'(valid_v), 128'(0));
      wait_idle();
      sweep();
    end

    // second start 10 cycles into generation is ignored
    rand_keys();
    start_run(3'b111, 1'b1);
    repeat (9) @(negedge clk);
    rand_keys();
    start_v = 3'b111;
    chk("gen_ready", 128'(ready_v), 128'(0));
    @(negedge clk);
    start_v = '0;
    wait_idle();
    sweep();

    // reset mid-generation aborts
    rand_keys();
    start_run(3'b111, 1'b0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 128'(ready_v), 128'(3'b111));
    chk("abort_valid", 128'(valid_v), 128'(0));
    chk("abort_done", 128'(done_v), 128'(0));
    chk("abort_rk", rk_v[0] | rk_v[1] | rk_v[2], 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    exp_valid = '0;
    repeat (60) @(negedge clk);
    sweep();
    rand_keys();
    start_run(3'b111, 1'b1);
    wait_idle();
    exp_valid = 3'b111;
    sweep();

    // start during DONE cycle is ignored
    rand_keys();
    start_run(3'b100, 1'b1);
    t = 0;
    while (!done_v[2] && t < 70) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", 128'(done_v[2]), 128'(1));
    rand_keys();
    start_v = 3'b100;
    @(negedge clk);
    start_v = '0;
    chk("done_start_ignored", 128'(ready_v), 128'(3'b111));
    repeat (60) @(negedge clk);
    sweep();

`ifdef AES_KEYEXP_ZEROIZE_EN
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    clear_model();
    exp_valid = '0;
    chk("zeroize_valid", 128'(valid_v), 128'(0));
    chk("zeroize_ready", 128'(ready_v), 128'(3'b111));
    sweep();
    rand_keys();
    zeroize = 1'b1;
    start_v = 3'b111;
    @(negedge clk);
    zeroize = 1'b0;
    start_v = '0;
    chk("zeroize_over_start", 128'(ready_v), 128'(3'b111));
    repeat (60) @(negedge clk);
    sweep();
`endif

    repeat (3) @(negedge clk);
    chk("done_q_empty", 128'(done_q.size()), 128'(0));
    chk("rd_q_empty", 128'(rd_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
